lfsr_checker: RTL and testbench

Receive-side checker for the 32-bit Fibonacci PRNG stream. It accepts one generated word per valid cycle and self-synchronises by seeding its reference LFSR from the incoming data. Once locked, it free-runs the reference, compares every incoming word against it, and counts word and bit errors. It sits at the sink end of a PRNG link (loopback, FIFO or board-to-board path) and provides pass/fail status for the Nexys A7 PRNG test setup.

---
 rtl/prng_pkg.sv | 30 +++
 rtl/lfsr_checker_popcount.sv | 21 ++
 rtl/lfsr_checker.sv | 189 ++++++++++++++++++
 tb/tb_lfsr_checker.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the 32-bit Fibonacci PRNG link (generator and checker).
//   PRNG_W      : word width (32)
//   TAP_*       : feedback tap positions in 1-based MSB-first numbering
//   state_e     : checker state (SEARCH / LOCKED)
//   next_state  : one LFSR step; new bit enters at position 1, rest shift toward N
//   sat_add32   : 32-bit add that clamps at 0xFFFFFFFF instead of wrapping
package prng_pkg;

  localparam int PRNG_W = 32;
  localparam int TAP_A  = 32;
  localparam int TAP_B  = 22;
  localparam int TAP_C  = 2;
  localparam int TAP_D  = 1;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic [1:PRNG_W] next_state(input logic [1:PRNG_W] x);
    return {x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D], x[1:PRNG_W-1]};
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/lfsr_checker_popcount.sv
// popcount32: combinational population count of a 32-bit word.
//   i_word  in  [31:0]  word to count
//   o_count out [5:0]   number of set bits (0..32)
module popcount32 (
  input  logic [31:0] i_word,
  output logic [5:0]  o_count
);

  logic [5:0] w_sum;

  // Accumulate the set bits one position at a time.
  always_comb begin
    w_sum = 6'd0;
    for (int i = 0; i < 32; i++) begin
      w_sum = w_sum + {5'd0, i_word[i]};
    end
  end

  assign o_count = w_sum;

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 32-bit Fibonacci PRNG stream.
// Self-synchronises by seeding its reference from incoming words, then
// flywheels the reference once locked and counts word and bit errors.
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   in_valid      in   in_word carries a new stream word
//   in_word       in   [1:N] received word, bit 1 = MSB
//   clear_counts  in   synchronous clear of err_words / err_bits
//   locked        out  checker is in LOCKED
//   err           out  one-cycle pulse per mismatching word while locked
//   err_words     out  saturating count of mismatching words
//   err_bits      out  saturating count of mismatching bits
module lfsr_checker
  import prng_pkg::*;
#(
  parameter int N          = 32,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:N]  in_word,
  input  logic        clear_counts,
  output logic        locked,
  output logic        err,
  output logic [31:0] err_words,
  output logic [31:0] err_bits
);

  localparam logic [3:0] LP_LOCK = 4'(LOCK_COUNT);
  localparam logic [3:0] LP_LOSS = 4'(LOSS_COUNT);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:N]  r_ref;
  logic        r_have_ref;
  logic [3:0]  r_match_cnt;
  logic [3:0]  r_miss_cnt;
  logic        r_err;
  logic [31:0] r_err_words;
  logic [31:0] r_err_bits;

  logic [1:N]  w_pred;
  logic [1:N]  w_diff;
  logic [5:0]  w_pop;
  logic [3:0]  w_match_inc;
  logic [3:0]  w_miss_inc;
  logic        w_search_match;
  logic        w_lock_hit;
  logic        w_mismatch;
  logic        w_loss_hit;

  logic [1:N]  w_ref_nxt;
  logic        w_have_nxt;
  logic [3:0]  w_match_nxt;
  logic [3:0]  w_miss_nxt;
  logic [31:0] w_words_base;
  logic [31:0] w_bits_base;
  logic [31:0] w_words_nxt;
  logic [31:0] w_bits_nxt;

  assign w_pred      = next_state(r_ref);
  assign w_diff      = in_word ^ w_pred;
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 4'd1;

  // An all-zero word can never count as a match, so a stuck-at-0 link cannot lock.
  assign w_search_match = r_have_ref && (in_word == w_pred) && (in_word != {N{1'b0}});
  assign w_lock_hit     = in_valid && (r_state == SEARCH) && w_search_match && (w_match_inc == LP_LOCK);
  assign w_mismatch     = in_valid && (r_state == LOCKED) && (in_word != w_pred);
  assign w_loss_hit     = w_mismatch && (w_miss_inc == LP_LOSS);

  popcount32 u_popcount (
    .i_word  (w_diff),
    .o_count (w_pop)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: lock after enough consecutive predictions, drop after enough misses.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEARCH: begin
        if (w_lock_hit) w_state_nxt = LOCKED;
        else            w_state_nxt = SEARCH;
      end
      LOCKED: begin
        if (w_loss_hit) w_state_nxt = SEARCH;
        else            w_state_nxt = LOCKED;
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  // Datapath next values: reference, run counters and error counters.
  always_comb begin
    w_ref_nxt   = r_ref;
    w_have_nxt  = r_have_ref;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    if (in_valid) begin
      case (r_state)
        SEARCH: begin
          // Every searched word reseeds the reference; on lock it equals the prediction anyway.
          w_ref_nxt  = in_word;
          w_have_nxt = 1'b1;
          if (w_search_match) w_match_nxt = w_match_inc;
          else                w_match_nxt = 4'd0;
          if (w_lock_hit) w_miss_nxt = 4'd0;
          else            w_miss_nxt = r_miss_cnt;
        end
        LOCKED: begin
          if (w_loss_hit) begin
            // Back to search, seeded from the word that broke the lock.
            w_ref_nxt   = in_word;
            w_match_nxt = 4'd0;
            w_miss_nxt  = 4'd0;
          end else if (w_mismatch) begin
            // Flywheel: keep predicting, never resync to a bad word.
            w_ref_nxt  = w_pred;
            w_miss_nxt = w_miss_inc;
          end else begin
            w_ref_nxt  = w_pred;
            w_miss_nxt = 4'd0;
          end
        end
        default: begin
          w_ref_nxt   = r_ref;
          w_match_nxt = 4'd0;
          w_miss_nxt  = 4'd0;
        end
      endcase
    end else begin
      w_ref_nxt = r_ref;
    end

    // Clear takes effect first, so a same-cycle error counts from zero.
    if (clear_counts) begin
      w_words_base = 32'd0;
      w_bits_base  = 32'd0;
    end else begin
      w_words_base = r_err_words;
      w_bits_base  = r_err_bits;
    end
    if (w_mismatch) begin
      w_words_nxt = sat_add32(w_words_base, 32'd1);
      w_bits_nxt  = sat_add32(w_bits_base, {26'd0, w_pop});
    end else begin
      w_words_nxt = w_words_base;
      w_bits_nxt  = w_bits_base;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref       <= {N{1'b0}};
      r_have_ref  <= 1'b0;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_err       <= 1'b0;
      r_err_words <= 32'd0;
      r_err_bits  <= 32'd0;
    end else begin
      r_ref       <= w_ref_nxt;
      r_have_ref  <= w_have_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_err       <= w_mismatch;
      r_err_words <= w_words_nxt;
      r_err_bits  <= w_bits_nxt;
    end
  end

  assign locked    = (r_state == LOCKED);
  assign err       = r_err;
  assign err_words = r_err_words;
  assign err_bits  = r_err_bits;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker and popcount32.
module tb_lfsr_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:32] in_word;
  logic        clear_counts;
  logic        locked;
  logic        err;
  logic [31:0] err_words;
  logic [31:0] err_bits;
  logic [31:0] pc_in;
  logic [5:0]  pc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.N(32), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_word      (in_word),
    .clear_counts (clear_counts),
    .locked       (locked),
    .err          (err),
    .err_words    (err_words),
    .err_bits     (err_bits)
  );

  popcount32 u_pc (.i_word(pc_in), .o_count(pc_out));

  // Reference model state
  bit          m_locked, m_have, m_err;
  logic [31:0] m_ref;
  int          m_match, m_miss;
  longint      m_words, m_bits;
  logic [31:0] g;

  typedef struct { logic [31:0] in; int unsigned cnt; } pc_vec_t;
  typedef struct { logic [31:0] word; bit exp_locked; } lock_vec_t;

  // Generator step in plain integer form: feedback from value bits 0,10,30,31 enters at bit 31.
  function automatic logic [31:0] gen_next(input logic [31:0] v);
    logic [31:0] fb;
    fb = 32'((v >> 0) & 1) ^ 32'((v >> 10) & 1) ^ 32'((v >> 30) & 1) ^ 32'((v >> 31) & 1);
    return (v >> 1) | (fb << 31);
  endfunction

  function automatic longint sat(input longint x);
    return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_err = 0; m_ref = 32'd0;
    m_match = 0; m_miss = 0; m_words = 0; m_bits = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] w, input bit clr);
    logic [31:0] p;
    m_err = 0;
    if (clr) begin m_words = 0; m_bits = 0; end
    if (v) begin
      p = gen_next(m_ref);
      if (!m_locked) begin
        if (m_have && w == p && w != 32'd0) m_match++;
        else m_match = 0;
        m_ref = w; m_have = 1;
        if (m_match == LOCK_N) begin m_locked = 1; m_miss = 0; end
      end else begin
        m_ref = p;
        if (w != p) begin
          m_err = 1;
          m_words = sat(m_words + 1);
          m_bits = sat(m_bits + $countones(w ^ p));
          m_miss++;
          if (m_miss == LOSS_N) begin m_locked = 0; m_match = 0; m_ref = w; end
        end else begin
          m_miss = 0;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".locked"}, {31'd0, locked}, {31'd0, m_locked});
    check({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    check({tag, ".err_words"}, err_words, m_words[31:0]);
    check({tag, ".err_bits"}, err_bits, m_bits[31:0]);
  endtask

  task automatic step(input bit v, input logic [31:0] w, input bit clr, input string tag);
    in_valid = v; in_word = w; clear_counts = clr;
    @(posedge clk); #1;
    model_step(v, w, clr);
    check_model(tag);
    in_valid = 1'b0; clear_counts = 1'b0;
  endtask

  task automatic send_gen(input logic [31:0] mask, input bit clr, input string tag);
    step(1'b1, g ^ mask, clr, tag);
    g = gen_next(g);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_word = 32'd0; clear_counts = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_model("reset");
    reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pc_vec_t   pcv[8];
    lock_vec_t lv[5];
    logic [31:0] w;
    logic [31:0] words_before;
    int nvalid;

    // popcount32 in isolation
    pcv[0] = '{32'h0000_0000, 0};
    pcv[1] = '{32'hFFFF_FFFF, 32};
    pcv[2] = '{32'h0000_0101, 2};
    pcv[3] = '{32'h8000_0001, 2};
    pcv[4] = '{32'hAAAA_AAAA, 16};
    pcv[5] = '{32'h0000_000F, 4};
    pcv[6] = '{32'h1234_5678, 13};
    pcv[7] = '{32'h0000_0007, 3};
    for (int i = 0; i < 8; i++) begin
      pc_in = pcv[i].in; #1;
      check("popcount_table", {26'd0, pc_out}, pcv[i].cnt);
    end
    for (int i = 0; i < 200; i++) begin
      pc_in = $urandom; #1;
      check("popcount_rand", {26'd0, pc_out}, $countones(pc_in));
    end

    // Clean lock with seed 2, checked against the known stream
    lv[0] = '{32'h0000_0002, 1'b0};
    lv[1] = '{32'h0000_0001, 1'b0};
    lv[2] = '{32'h8000_0000, 1'b0};
    lv[3] = '{32'hC000_0000, 1'b0};
    lv[4] = '{32'h6000_0000, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, lv[i].word, 1'b0, "lock_tbl");
      check("lock_tbl_locked", {31'd0, locked}, {31'd0, lv[i].exp_locked});
      check("lock_tbl_err", {31'd0, err}, 32'd0);
    end
    g = gen_next(32'h6000_0000);
    for (int i = 5; i < 10000; i++) send_gen(32'd0, 1'b0, "clean");
    check("clean_words", err_words, 32'd0);
    check("clean_bits", err_bits, 32'd0);
    check("clean_locked", {31'd0, locked}, 32'd1);

    // Single two-bit flip while locked; flywheel must not resync
    send_gen(32'h0000_0101, 1'b0, "flip");
    check("flip_err", {31'd0, err}, 32'd1);
    check("flip_words", err_words, 32'd1);
    check("flip_bits", err_bits, 32'd2);
    check("flip_locked", {31'd0, locked}, 32'd1);
    send_gen(32'd0, 1'b0, "after_flip");
    check("after_flip_err", {31'd0, err}, 32'd0);
    check("after_flip_locked", {31'd0, locked}, 32'd1);

    // Three corrupted words then a clean one: lock holds
    for (int i = 0; i < 3; i++) send_gen($urandom | 32'd1, 1'b0, "three_bad");
    check("three_bad_locked", {31'd0, locked}, 32'd1);
    send_gen(32'd0, 1'b0, "three_bad_clean");
    check("three_bad_clean_locked", {31'd0, locked}, 32'd1);
    check("three_bad_clean_err", {31'd0, err}, 32'd0);

    // Loss after four random words, then relock
    step(1'b0, 32'd0, 1'b1, "clear");
    check("clear_words", err_words, 32'd0);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      if (w == g) w = w ^ 32'd1;
      step(1'b1, w, 1'b0, "loss");
      g = gen_next(g);
      if (i < 3) check("loss_hold", {31'd0, locked}, 32'd1);
    end
    check("loss_words", err_words, 32'd4);
    check("loss_locked", {31'd0, locked}, 32'd0);
    check("loss_err", {31'd0, err}, 32'd1);
    for (int i = 0; i < 4; i++) send_gen(32'd0, 1'b0, "relock");
    check("relock_early", {31'd0, locked}, 32'd0);
    send_gen(32'd0, 1'b0, "relock");
    check("relock", {31'd0, locked}, 32'd1);
    check("relock_words", err_words, 32'd4);

    // Clear in the same cycle as a 3-bit error
    send_gen(32'h0000_0001, 1'b0, "pre_clear");
    send_gen(32'h0000_0007, 1'b1, "clear_err");
    check("clear_err_words", err_words, 32'd1);
    check("clear_err_bits", err_bits, 32'd3);
    send_gen(32'd0, 1'b0, "clear_err_clean");

    // Saturation from forced near-full counters
    force dut.r_err_words = 32'hFFFF_FFFE;
    force dut.r_err_bits  = 32'hFFFF_FFFD;
    #1;
    release dut.r_err_words;
    release dut.r_err_bits;
    m_words = 64'hFFFF_FFFE; m_bits = 64'hFFFF_FFFD;
    send_gen(32'h0000_0003, 1'b0, "sat1");
    check("sat1_words", err_words, 32'hFFFF_FFFF);
    check("sat1_bits", err_bits, 32'hFFFF_FFFF);
    send_gen(32'h0000_0007, 1'b0, "sat2");
    check("sat2_words", err_words, 32'hFFFF_FFFF);
    check("sat2_bits", err_bits, 32'hFFFF_FFFF);
    send_gen(32'd0, 1'b0, "sat_clean");

    // Asynchronous reset mid-lock
    check("pre_reset_locked", {31'd0, locked}, 32'd1);
    reset = 1'b1; #2;
    check("async_reset_locked", {31'd0, locked}, 32'd0);
    check("async_reset_words", err_words, 32'd0);
    check("async_reset_bits", err_bits, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // All-zero input from reset
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 32'd0, 1'b0, "zero");
    check("zero_locked", {31'd0, locked}, 32'd0);
    check("zero_words", err_words, 32'd0);

    // Valid gaps 1,0,0,1 with junk data on idle cycles
    do_reset();
    g = 32'h0000_0002;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      if ((i % 4 == 0) || (i % 4 == 3)) begin
        send_gen(32'd0, 1'b0, "gap");
        nvalid++;
        check("gap_locked", {31'd0, locked}, (nvalid >= 5) ? 32'd1 : 32'd0);
      end else begin
        step(1'b0, $urandom, 1'b0, "gap_idle");
      end
    end
    check("gap_words", err_words, 32'd0);

    // Randomised traffic against the model
    do_reset();
    g = $urandom | 32'd1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit clr;
      r = $urandom_range(0, 99);
      clr = ($urandom_range(0, 63) == 0);
      if (r < 15) begin
        step(1'b0, $urandom, clr, "rnd_idle");
      end else if (r < 20) begin
        send_gen(32'd1 << $urandom_range(0, 31), clr, "rnd_bit");
      end else if (r < 23) begin
        send_gen($urandom, clr, "rnd_word");
      end else if (r < 24) begin
        for (int k = 0; k < 5; k++) send_gen($urandom | 32'd1, 1'b0, "rnd_burst");
      end else begin
        send_gen(32'd0, clr, "rnd_clean");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
